// File: rtl/pipeline_scoreboard_if.sv
// Issue-side bundle for the pipeline scoreboard: issue request, branch
// kill pulse, and hazard/forwarding/perf results returned to the issuer.
interface pipeline_scoreboard_if #(
  parameter int REG_W  = 4,
  parameter int LAT_W  = 3,
  parameter int PERF_W = 16
);
  logic              issue_valid;
  logic [REG_W-1:0]  issue_rs;
  logic [REG_W-1:0]  issue_rt;
  logic [REG_W-1:0]  issue_rd;
  logic              issue_rs_en;
  logic              issue_rt_en;
  logic              issue_rd_en;
  logic [LAT_W-1:0]  issue_lat;
  logic              branch_taken;
  logic              issue_accept;
  logic              stall;
  logic              flush;
  logic              fwd_a;
  logic              fwd_b;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_cycles;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_rs_en, issue_rt_en,
           issue_rd_en, issue_lat, branch_taken,
    input  issue_accept, stall, flush, fwd_a, fwd_b, busy, stall_cycles, flush_cycles
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_rs_en, issue_rt_en,
           issue_rd_en, issue_lat, branch_taken,
    output issue_accept, stall, flush, fwd_a, fwd_b, busy, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// In-order issue scoreboard: per-register result countdown, RAW/WAW stall,
// bypass-forward detection, taken-branch flush window and perf counters.
module pipeline_scoreboard_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [LAT_W-1:0] set_cnt,
  output logic             pending,
  output logic [LAT_W-1:0] cnt
);
  // A new writer overrides the retiring one in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (set) begin
      pending <= 1'b1;
      cnt     <= set_cnt;
    end else if (pending) begin
      cnt <= cnt - LAT_W'(1);
      if (cnt == LAT_W'(1)) pending <= 1'b0;
    end
  end
endmodule

module pipeline_scoreboard #(
  parameter int REG_W        = 4,
  parameter int LAT_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int ZERO_REG     = 1,
  parameter int PERF_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_scoreboard_if.slave  sb
);
  localparam int NUM_REGS = 2**REG_W;

  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            set;
  logic [LAT_W-1:0]               lat_eff;
  logic                           rd_hit, rs_pend, rt_pend, rs_raw, rt_raw, waw;
  logic                           stall, flush, accept;
  logic [7:0]                     fcnt;
  logic [PERF_W-1:0]              stall_cnt, flush_cnt;

  assign lat_eff = (sb.issue_lat == '0) ? LAT_W'(1) : sb.issue_lat;
  assign rd_hit  = sb.issue_rd_en && !((ZERO_REG != 0) && (sb.issue_rd == '0));

  // A source whose producer is one cycle out is on the bypass bus now.
  assign rs_pend = sb.issue_rs_en && pending[sb.issue_rs];
  assign rt_pend = sb.issue_rt_en && pending[sb.issue_rt];
  assign rs_raw  = rs_pend && (cnt[sb.issue_rs] > LAT_W'(1));
  assign rt_raw  = rt_pend && (cnt[sb.issue_rt] > LAT_W'(1));
  assign waw     = rd_hit && pending[sb.issue_rd] && (lat_eff < cnt[sb.issue_rd]);

  assign stall  = sb.issue_valid && (rs_raw || rt_raw || waw);
  assign flush  = sb.branch_taken || (fcnt != 8'd0);
  assign accept = sb.issue_valid && !stall && !flush;

  assign sb.stall        = stall;
  assign sb.flush        = flush;
  assign sb.issue_accept = accept;
  assign sb.fwd_a        = sb.issue_valid && rs_pend && (cnt[sb.issue_rs] == LAT_W'(1));
  assign sb.fwd_b        = sb.issue_valid && rt_pend && (cnt[sb.issue_rt] == LAT_W'(1));
  assign sb.busy         = |pending;
  assign sb.stall_cycles = stall_cnt;
  assign sb.flush_cycles = flush_cnt;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign set[r] = accept && rd_hit && (sb.issue_rd == REG_W'(r));
    pipeline_scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (set[r]),
      .set_cnt (lat_eff),
      .pending (pending[r]),
      .cnt     (cnt[r])
    );
  end

  // Flush window restarts on every taken branch; issued work keeps counting.
  always_ff @(posedge clk) begin
    if (rst)                  fcnt <= 8'd0;
    else if (sb.branch_taken) fcnt <= 8'(FLUSH_CYCLES);
    else if (fcnt != 8'd0)    fcnt <= fcnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
endmodule
